// File: rtl/wb_master_bridge_pkg.sv
// Shared constants, size codes and FSM state encoding for the Wishbone master bridge.
package wb_master_bridge_pkg;

  localparam logic [31:0] WORD_ZERO  = 32'h0000_0000;
  localparam int          BYTE_WIDTH = 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUS   = 2'b01,
    ST_RWAIT = 2'b10
  } state_t;

endpackage

// File: rtl/wb_lane_align.sv
// Combinational lane handling: byte-enable generation, store-data replication,
// load-data extraction with zero extension, and alignment checking.
module wb_lane_align
  import wb_master_bridge_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic        illegal,
  input  logic [1:0]  rsp_size,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rsp_data,
  output logic [31:0] rdata_ext
);

  logic [31:0] rsp_shift;

  always_comb begin
    sel       = 4'b0000;
    wdata_rep = WORD_ZERO;
    illegal   = 1'b0;
    case (req_size)
      SIZE_BYTE: begin
        sel       = 4'b0001 << req_addr_lo;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        sel       = req_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
        illegal   = req_addr_lo[0];
      end
      SIZE_WORD: begin
        sel       = 4'b1111;
        wdata_rep = req_wdata;
        illegal   = |req_addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Loads come back on their natural lanes; shift them down to bit 0.
  always_comb begin
    rsp_shift = rsp_data >> (rsp_addr_lo * BYTE_WIDTH);
    rdata_ext = WORD_ZERO;
    case (rsp_size)
      SIZE_BYTE: rdata_ext = {24'h0, rsp_shift[7:0]};
      SIZE_HALF: rdata_ext = {16'h0, rsp_shift[15:0]};
      SIZE_WORD: rdata_ext = rsp_data;
      default:   rdata_ext = WORD_ZERO;
    endcase
  end

endmodule

// File: rtl/wb_master_bridge.sv
// LSU-to-Wishbone initiator: one registered bus cycle per request, with retry and error handling.
// Define WB_TIMEOUT_EN to add a no-response timeout that ends a stuck cycle with an error.
module wb_master_bridge
  import wb_master_bridge_pkg::*;
#(
  parameter int MAX_RETRY = 4,
  parameter int RETRY_GAP = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [1:0]  cpu_size_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_done_o,
  output logic        cpu_err_o,
  output logic        cpu_busy_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW  = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRY);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(RETRY_GAP - 1);

  state_t          state;
  logic            cyc;
  logic [RCW-1:0]  retry_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [1:0]      size_q;
  logic [1:0]      addr_lo_q;
  logic [3:0]      sel_nxt;
  logic [31:0]     wdata_rep;
  logic [31:0]     rdata_ext;
  logic            illegal;

`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
  logic [TW-1:0] tmo_cnt;
`endif

  assign wb_cyc_o   = cyc;
  assign wb_stb_o   = cyc;
  assign cpu_busy_o = (state != ST_IDLE);

  wb_lane_align u_lane_align (
    .req_size    (cpu_size_i),
    .req_addr_lo (cpu_addr_i[1:0]),
    .req_wdata   (cpu_wdata_i),
    .sel         (sel_nxt),
    .wdata_rep   (wdata_rep),
    .illegal     (illegal),
    .rsp_size    (size_q),
    .rsp_addr_lo (addr_lo_q),
    .rsp_data    (wb_data_i),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      cyc         <= 1'b0;
      wb_addr_o   <= WORD_ZERO;
      wb_data_o   <= WORD_ZERO;
      wb_sel_o    <= 4'b0000;
      wb_we_o     <= 1'b0;
      size_q      <= SIZE_BYTE;
      addr_lo_q   <= 2'b00;
      retry_cnt   <= '0;
      gap_cnt     <= '0;
      cpu_done_o  <= 1'b0;
      cpu_err_o   <= 1'b0;
      cpu_rdata_o <= WORD_ZERO;
`ifdef WB_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      cpu_done_o <= 1'b0;
      cpu_err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          retry_cnt <= '0;
          gap_cnt   <= '0;
          if (cpu_req_i) begin
            if (illegal) begin
              cpu_done_o <= 1'b1;
              cpu_err_o  <= 1'b1;
            end else begin
              state     <= ST_BUS;
              cyc       <= 1'b1;
              wb_addr_o <= {cpu_addr_i[31:2], 2'b00};
              wb_data_o <= wdata_rep;
              wb_sel_o  <= sel_nxt;
              wb_we_o   <= cpu_we_i;
              size_q    <= cpu_size_i;
              addr_lo_q <= cpu_addr_i[1:0];
`ifdef WB_TIMEOUT_EN
              tmo_cnt   <= TMO_LOAD;
`endif
            end
          end
        end

        // err outranks ack, which outranks rty.
        ST_BUS: begin
          if (wb_err_i) begin
            cyc         <= 1'b0;
            state       <= ST_IDLE;
            cpu_done_o  <= 1'b1;
            cpu_err_o   <= 1'b1;
            cpu_rdata_o <= WORD_ZERO;
          end else if (wb_ack_i) begin
            cyc        <= 1'b0;
            state      <= ST_IDLE;
            cpu_done_o <= 1'b1;
            if (!wb_we_o) cpu_rdata_o <= rdata_ext;
          end else if (wb_rty_i) begin
            cyc <= 1'b0;
            if (retry_cnt == RETRY_MAX) begin
              state      <= ST_IDLE;
              cpu_done_o <= 1'b1;
              cpu_err_o  <= 1'b1;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              gap_cnt   <= '0;
              state     <= ST_RWAIT;
            end
          end
`ifdef WB_TIMEOUT_EN
          else if (tmo_cnt == TW'(1)) begin
            cyc        <= 1'b0;
            state      <= ST_IDLE;
            cpu_done_o <= 1'b1;
            cpu_err_o  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end

        // Bus outputs were left untouched, so re-raising cyc re-issues the same access.
        ST_RWAIT: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_BUS;
            cyc   <= 1'b1;
`ifdef WB_TIMEOUT_EN
            tmo_cnt <= TMO_LOAD;
`endif
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          cyc   <= 1'b0;
        end
      endcase
    end
  end

endmodule
